mouse_transmitter: RTL and testbench

MOUSE_TRANSMITTER -- requirements
Module: mouse_transmitter

---
 rtl/mouse_pkg.sv | 36 +++
 rtl/ps2_sync_edge.sv | 34 +++
 rtl/mouse_transmitter.sv | 180 ++++++++++++++++++
 tb/tb_mouse_transmitter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse host-side transmitter.
//   INHIBIT_CYCLES_DEF / TIMEOUT_CYCLES_DEF : default timing (CLK cycles at 50 MHz)
//   tx_state_t : transmitter FSM encoding
//   tx_cmd_t   : latched command byte plus its odd parity bit
package mouse_pkg;

  localparam int unsigned INHIBIT_CYCLES_DEF = 5000;    // 100 us
  localparam int unsigned TIMEOUT_CYCLES_DEF = 750000;  // 15 ms
  localparam int unsigned FRAME_W            = 16;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    INHIBIT      = 3'd1,
    REQ_START    = 3'd2,
    SEND_BITS    = 3'd3,
    WAIT_ACK     = 3'd4,
    WAIT_RELEASE = 3'd5
  } tx_state_t;

  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } tx_cmd_t;

  // Odd parity: bit is 1 when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Line level per falling-edge index: 0 start, 1-8 data LSB first,
  // 9 parity, 10 and above released (stop / idle).
  function automatic logic [FRAME_W-1:0] build_frame(input tx_cmd_t c);
    return {5'b11111, 1'b1, c.parity, c.data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line plus falling-edge detector.
//   CLK, RESET : system clock, async active-high reset (flops reset to idle 1)
//   line_in    : raw line level
//   line_sync  : synchronized level
//   fall_c     : one-cycle strobe when the synchronized level goes 1 -> 0
module ps2_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic line_in,
  output logic line_sync,
  output logic fall_c
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign line_sync = sync;
  assign fall_c    = prev & ~sync;

endmodule

// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device byte transmitter (command path to a mouse).
//   CLK, RESET          : system clock, async active-high reset
//   CLK_MOUSE_IN        : raw PS/2 clock level
//   DATA_MOUSE_IN       : raw PS/2 data level
//   CLK_MOUSE_OUT_EN    : 1 pulls PS/2 clock low
//   DATA_MOUSE_OUT_EN   : 1 pulls PS/2 data low
//   SEND_BYTE           : request strobe, honoured only when idle
//   BYTE_TO_SEND        : command byte
//   BUSY                : transaction in progress
//   BYTE_SENT / ERROR   : one-cycle completion / failure pulses
module mouse_transmitter
  import mouse_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic       ERROR
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  tx_state_t          state, state_d;
  logic [INH_W-1:0]   inh_cnt, inh_cnt_d;
  logic [3:0]         bit_cnt, bit_cnt_d;
  logic [TO_W-1:0]    to_cnt, to_cnt_d;
  tx_cmd_t            cmd, cmd_d;
  logic               sent_c, fail_c;

  logic               clk_en_d, data_en_d, busy_d, sent_d, err_d;
  logic [FRAME_W-1:0] frame;

  logic clk_lvl, clk_fall_c;
  logic data_lvl, data_fall_unused;

  ps2_sync_edge u_clk_sync (
    .CLK       (CLK),
    .RESET     (RESET),
    .line_in   (CLK_MOUSE_IN),
    .line_sync (clk_lvl),
    .fall_c    (clk_fall_c)
  );

  ps2_sync_edge u_data_sync (
    .CLK       (CLK),
    .RESET     (RESET),
    .line_in   (DATA_MOUSE_IN),
    .line_sync (data_lvl),
    .fall_c    (data_fall_unused)
  );

  // State, counters, latched command and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state             <= IDLE;
      inh_cnt           <= '0;
      bit_cnt           <= '0;
      to_cnt            <= '0;
      cmd               <= '0;
      CLK_MOUSE_OUT_EN  <= 1'b0;
      DATA_MOUSE_OUT_EN <= 1'b0;
      BUSY              <= 1'b0;
      BYTE_SENT         <= 1'b0;
      ERROR             <= 1'b0;
    end else begin
      state             <= state_d;
      inh_cnt           <= inh_cnt_d;
      bit_cnt           <= bit_cnt_d;
      to_cnt            <= to_cnt_d;
      cmd               <= cmd_d;
      CLK_MOUSE_OUT_EN  <= clk_en_d;
      DATA_MOUSE_OUT_EN <= data_en_d;
      BUSY              <= busy_d;
      BYTE_SENT         <= sent_d;
      ERROR             <= err_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d   = state;
    inh_cnt_d = inh_cnt;
    bit_cnt_d = bit_cnt;
    to_cnt_d  = to_cnt;
    cmd_d     = cmd;
    sent_c    = 1'b0;
    fail_c    = 1'b0;

    case (state)
      IDLE: begin
        inh_cnt_d = '0;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        if (SEND_BYTE) begin
          cmd_d.data   = BYTE_TO_SEND;
          cmd_d.parity = odd_parity(BYTE_TO_SEND);
          state_d      = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          inh_cnt_d = '0;
          state_d   = REQ_START;
        end else begin
          inh_cnt_d = inh_cnt + INH_W'(1);
        end
      end
      REQ_START: begin
        if (clk_fall_c) begin
          bit_cnt_d = 4'd1;
          state_d   = SEND_BITS;
        end
      end
      SEND_BITS: begin
        if (clk_fall_c) begin
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) begin
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (clk_fall_c) begin
          if (!data_lvl) begin
            state_d = WAIT_RELEASE;
          end else begin
            state_d = IDLE;
            fail_c  = 1'b1;
          end
        end
      end
      WAIT_RELEASE: begin
        if (clk_lvl && data_lvl) begin
          state_d = IDLE;
          sent_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Transaction watchdog overrides any progress made in the same cycle.
    if (state inside {REQ_START, SEND_BITS, WAIT_ACK, WAIT_RELEASE}) begin
      if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        sent_c  = 1'b0;
        fail_c  = 1'b1;
      end else begin
        to_cnt_d = to_cnt + TO_W'(1);
      end
    end
  end

  // Output values for the next cycle, derived from the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    frame     = build_frame(cmd);
    clk_en_d  = (state_d == INHIBIT);
    data_en_d = 1'b0;
    busy_d    = (state_d != IDLE);
    sent_d    = sent_c;
    err_d     = fail_c;

    case (state_d)
      INHIBIT:              data_en_d = (inh_cnt_d == INH_W'(INHIBIT_CYCLES - 1));
      REQ_START, SEND_BITS: data_en_d = ~frame[bit_cnt_d];
      default:              data_en_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mouse_transmitter.sv
// Self-checking bench for mouse_transmitter with a PS/2 device model.
module tb_mouse_transmitter;

  localparam int INH      = 5000;
  localparam int TMO      = 1000;
  localparam int DEV_HALF = 25;   // device clock half period in CLK cycles

  logic       CLK;
  logic       RESET;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       CLK_MOUSE_OUT_EN;
  logic       DATA_MOUSE_OUT_EN;
  logic       BUSY;
  logic       BYTE_SENT;
  logic       ERROR;

  logic dev_clk_low;
  logic dev_data_low;
  logic clk_line;
  logic data_line;

  // Open-drain wired-AND of host and device drivers.
  assign clk_line  = ~(CLK_MOUSE_OUT_EN | dev_clk_low);
  assign data_line = ~(DATA_MOUSE_OUT_EN | dev_data_low);

  mouse_transmitter #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .CLK_MOUSE_IN      (clk_line),
    .DATA_MOUSE_IN     (data_line),
    .CLK_MOUSE_OUT_EN  (CLK_MOUSE_OUT_EN),
    .DATA_MOUSE_OUT_EN (DATA_MOUSE_OUT_EN),
    .SEND_BYTE         (SEND_BYTE),
    .BYTE_TO_SEND      (BYTE_TO_SEND),
    .BUSY              (BUSY),
    .BYTE_SENT         (BYTE_SENT),
    .ERROR             (ERROR)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  typedef struct {
    logic [10:0] frame;
    bit          has_frame;
    int          n_sent;
    int          n_err;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  int sent_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int busy_overlap = 0;
  int inh_len = 0;
  int data_rise_at = 0;
  bit clk_en_q = 1'b0;
  int base_sent = 0;
  int base_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_parity(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Pulse counters and INHIBIT-phase measurements.
  always @(negedge CLK) begin
    if (CLK_MOUSE_OUT_EN) begin
      if (!clk_en_q) begin
        inh_len      = 0;
        data_rise_at = 0;
      end
      inh_len++;
      if (DATA_MOUSE_OUT_EN && data_rise_at == 0) data_rise_at = inh_len;
    end
    clk_en_q = CLK_MOUSE_OUT_EN;
    if (BYTE_SENT) sent_cnt++;
    if (ERROR) err_cnt++;
    if (BYTE_SENT && ERROR) both_cnt++;
    if ((BYTE_SENT || ERROR) && BUSY) busy_overlap++;
  end

  task automatic send(input logic [7:0] b, input bit has_frame, input int n_sent, input int n_errs);
    exp_t e;
    e.frame     = {1'b1, ref_parity(b), b, 1'b0};
    e.has_frame = has_frame;
    e.n_sent    = n_sent;
    e.n_err     = n_errs;
    exp_q.push_back(e);
    base_sent = sent_cnt;
    base_err  = err_cnt;
    @(negedge CLK);
    BYTE_TO_SEND = b;
    SEND_BYTE    = 1'b1;
    @(negedge CLK);
    SEND_BYTE    = 1'b0;
    BYTE_TO_SEND = ~b;
    check_eq("busy_on_accept", 32'(BUSY), 32'd1);
  endtask

  task automatic wait_req_start(output bit found);
    int t;
    t = 0;
    while (!(CLK_MOUSE_OUT_EN === 1'b0 && DATA_MOUSE_OUT_EN === 1'b1) && t < 20000) begin
      @(negedge CLK);
      t++;
    end
    found = (t < 20000);
  endtask

  // Device: clocks n_edges falling edges, captures start bit and the bit
  // driven after each edge, optionally pulls data low for the ack edge (11).
  task automatic device_run(input int n_edges, input bit ack, output logic [10:0] cap,
                            output bit found);
    cap = '1;
    wait_req_start(found);
    if (!found) return;
    cap[0] = data_line;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11 && ack) dev_data_low = 1'b1;
      repeat (DEV_HALF) @(negedge CLK);
      dev_clk_low = 1'b1;
      repeat (DEV_HALF) @(negedge CLK);
      dev_clk_low = 1'b0;
      if (k <= 10) cap[k] = data_line;
      dev_data_low = 1'b0;
    end
  endtask

  task automatic finish_txn(input logic [10:0] cap);
    exp_t e;
    int   t;
    t = 0;
    while (sent_cnt == base_sent && err_cnt == base_err && t < 300) begin
      @(negedge CLK);
      t++;
    end
    repeat (5) @(negedge CLK);
    e = exp_q.pop_front();
    if (e.has_frame) check_eq("frame", 32'(cap), 32'(e.frame));
    check_eq("byte_sent_pulses", 32'(sent_cnt - base_sent), 32'(e.n_sent));
    check_eq("error_pulses", 32'(err_cnt - base_err), 32'(e.n_err));
    check_eq("busy_idle", 32'(BUSY), 32'd0);
    check_eq("lines_released", 32'({CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}), 32'd0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  tbl [4];
    logic [10:0] cap;
    bit          found;
    int          cnt;

    tbl[0] = 8'hF4;
    tbl[1] = 8'hFF;
    tbl[2] = 8'h00;
    tbl[3] = 8'h81;

    RESET        = 1'b1;
    SEND_BYTE    = 1'b0;
    BYTE_TO_SEND = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("reset_outputs",
             32'({CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, BUSY, BYTE_SENT, ERROR}), 32'd0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    // Normal acknowledged transfers.
    foreach (tbl[i]) begin
      send(tbl[i], 1'b1, 1, 0);
      device_run(11, 1'b1, cap, found);
      check_eq("req_start_seen", 32'(found), 32'd1);
      check_eq("inhibit_len", 32'(inh_len), 32'(INH));
      check_eq("data_en_rise_cycle", 32'(data_rise_at), 32'(INH));
      finish_txn(cap);
    end

    // Missing acknowledge.
    send(8'h5A, 1'b1, 0, 1);
    device_run(11, 1'b0, cap, found);
    check_eq("req_start_seen_noack", 32'(found), 32'd1);
    finish_txn(cap);

    // Request while busy is ignored.
    send(8'hF4, 1'b1, 1, 0);
    repeat (10) @(negedge CLK);
    BYTE_TO_SEND = 8'h00;
    SEND_BYTE    = 1'b1;
    @(negedge CLK);
    SEND_BYTE    = 1'b0;
    device_run(11, 1'b1, cap, found);
    check_eq("req_start_seen_busy", 32'(found), 32'd1);
    finish_txn(cap);

    // Reset in the middle of the data bits (after edge 4).
    send(8'hA0, 1'b0, 0, 0);
    device_run(4, 1'b0, cap, found);
    check_eq("req_start_seen_rst", 32'(found), 32'd1);
    check_eq("pre_reset_data_en", 32'(DATA_MOUSE_OUT_EN), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check_eq("async_reset_outputs",
             32'({CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, BUSY}), 32'd0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    finish_txn(cap);

    // Device never clocks: watchdog timeout.
    send(8'h12, 1'b0, 0, 1);
    wait_req_start(found);
    check_eq("req_start_seen_tmo", 32'(found), 32'd1);
    cnt = 0;
    while (ERROR !== 1'b1 && cnt < 3000) begin
      @(negedge CLK);
      cnt++;
    end
    check_eq("timeout_cycles", 32'(cnt), 32'(TMO));
    check_eq("timeout_lines", 32'({CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}), 32'd0);
    finish_txn(cap);

    check_eq("sent_and_error_together", 32'(both_cnt), 32'd0);
    check_eq("busy_with_pulse", 32'(busy_overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
